// File: rtl/stream_encoder_m_if.sv
// axi4_lite_if: AXI4-Lite bundle used by stream_encoder_m.
// Only the read channels carry traffic. The write channels are reduced to the
// three handshake signals that the encoder ties inactive.
// Parameters: AW address width, DW data width.
// Modports: master (the encoder), slave (memory fabric / bench model).
interface axi4_lite_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          awvalid;
  logic          wvalid;
  logic          bready;

  modport master (
    output araddr, arvalid, rready, awvalid, wvalid, bready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awvalid, wvalid, bready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/stream_encoder_m.sv
// stream_encoder_m: fetches WORDS 32-bit words of shared memory over an
// AXI4-Lite read master and sends them as a framed 16-bit transceiver stream:
//   SOF {FB,seg_id} | HDR base[15:0] | DATA halves (upper first) | [CSUM] | EOF FDBC
// IDLE words (BCBC, both K) fill the line between frames.
// Optional feature macro: STREAM_ENCODER_CSUM_EN adds the 16-bit checksum word.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               frame request (ignored while busy)
//   base_addr, seg_id   frame parameters, sampled on accepted start
//   tx_ena              transceiver word strobe (consumes tx_data_out)
//   tx_data_out         {data[15:0], iskey[1:0]}
//   busy, err           frame in progress / sticky read error
//   shared_data_in_i    AXI4-Lite master (read only)
package stream_encoder_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  iskey;
  } xcvr_tx_data_word_t;

  localparam logic [15:0] K_IDLE   = 16'hBCBC;
  localparam logic [7:0]  K_SOF_HI = 8'hFB;
  localparam logic [15:0] K_EOF    = 16'hFDBC;
endpackage

module stream_encoder_m
  import stream_encoder_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AW-1:0]      base_addr,
  input  logic [7:0]         seg_id,
  input  logic               tx_ena,
  output xcvr_tx_data_word_t tx_data_out,
  output logic               busy,
  output logic               err,
  axi4_lite_if.master        shared_data_in_i
);

  localparam int unsigned CW = 9;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SOF   = 3'd2,
    S_HDR   = 3'd3,
    S_DATA  = 3'd4,
`ifdef STREAM_ENCODER_CSUM_EN
    S_CSUM  = 3'd5,
`endif
    S_EOF   = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;      // word index while fetching, half index while sending
  logic [AW-1:0] r_base;
  logic [7:0]    r_seg;
  logic          r_err;
  logic          r_ar_pend;  // 1: AR not yet accepted, 0: waiting for R
  logic [31:0]   r_buf [WORDS];
`ifdef STREAM_ENCODER_CSUM_EN
  logic [15:0]   r_csum;
`endif

  logic          w_arvalid;
  logic          w_rready;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_r_bad;
  logic          w_last_fetch;
  logic          w_last_half;
  logic [IW-1:0] w_fidx;
  logic [IW-1:0] w_didx;
  logic [31:0]   w_word;
  logic [15:0]   w_half;

  assign w_ar_hs      = w_arvalid && shared_data_in_i.arready;
  assign w_r_hs       = w_rready && shared_data_in_i.rvalid;
  assign w_r_bad      = (shared_data_in_i.rresp != 2'b00);
  assign w_last_fetch = (r_cnt == CW'(WORDS - 1));
  assign w_last_half  = (r_cnt == CW'(2 * WORDS - 1));
  assign w_fidx       = r_cnt[IW-1:0];
  assign w_didx       = r_cnt[IW:1];
  assign w_word       = r_buf[w_didx];
  assign w_half       = r_cnt[0] ? w_word[15:0] : w_word[31:16];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (w_r_hs) begin
          if (w_r_bad)           w_next = S_IDLE;
          else if (w_last_fetch) w_next = S_SOF;
        end
      end
      S_SOF:   if (tx_ena) w_next = S_HDR;
      S_HDR:   if (tx_ena) w_next = S_DATA;
`ifdef STREAM_ENCODER_CSUM_EN
      S_DATA:  if (tx_ena && w_last_half) w_next = S_CSUM;
      S_CSUM:  if (tx_ena) w_next = S_EOF;
`else
      S_DATA:  if (tx_ena && w_last_half) w_next = S_EOF;
`endif
      S_EOF:   if (tx_ena) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    tx_data_out.data  = K_IDLE;
    tx_data_out.iskey = 2'b11;
    busy              = (r_state != S_IDLE);
    w_arvalid         = 1'b0;
    w_rready          = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_arvalid = r_ar_pend;
        w_rready  = !r_ar_pend;
      end
      S_SOF: begin
        tx_data_out.data  = {K_SOF_HI, r_seg};
        tx_data_out.iskey = 2'b10;
      end
      S_HDR: begin
        tx_data_out.data  = 16'(r_base);
        tx_data_out.iskey = 2'b00;
      end
      S_DATA: begin
        tx_data_out.data  = w_half;
        tx_data_out.iskey = 2'b00;
      end
`ifdef STREAM_ENCODER_CSUM_EN
      S_CSUM: begin
        tx_data_out.data  = r_csum;
        tx_data_out.iskey = 2'b00;
      end
`endif
      S_EOF: begin
        tx_data_out.data  = K_EOF;
        tx_data_out.iskey = 2'b11;
      end
      default: ;
    endcase
  end

  assign err                      = r_err;
  assign shared_data_in_i.arvalid = w_arvalid;
  assign shared_data_in_i.rready  = w_rready;
  assign shared_data_in_i.araddr  = r_base + AW'({r_cnt, 2'b00});
  assign shared_data_in_i.awvalid = 1'b0;
  assign shared_data_in_i.wvalid  = 1'b0;
  assign shared_data_in_i.bready  = 1'b1;

  // Frame parameters, counters, error flag and checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_base    <= '0;
      r_seg     <= '0;
      r_err     <= 1'b0;
      r_ar_pend <= 1'b0;
`ifdef STREAM_ENCODER_CSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base    <= base_addr;
            r_seg     <= seg_id;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_ar_pend <= 1'b1;
`ifdef STREAM_ENCODER_CSUM_EN
            r_csum    <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (w_ar_hs) r_ar_pend <= 1'b0;
          if (w_r_hs) begin
            if (w_r_bad) begin
              r_err <= 1'b1;
            end else if (w_last_fetch) begin
              r_cnt <= '0;
            end else begin
              r_cnt     <= r_cnt + CW'(1);
              r_ar_pend <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tx_ena) begin
            r_cnt  <= r_cnt + CW'(1);
`ifdef STREAM_ENCODER_CSUM_EN
            r_csum <= r_csum + w_half;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Read buffer; contents are don't-care after reset or a failed fetch
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH && w_r_hs && !w_r_bad) r_buf[w_fidx] <= 32'(shared_data_in_i.rdata);
  end

endmodule

// File: doc/stream_encoder_m.md
# stream_encoder_m

Transmit-side counterpart of the shared-data stream decoder. On request it fetches one segment of shared memory over an AXI4-Lite read master and serialises it as a framed 16-bit transceiver word stream (`xcvr_tx_data_word_t`) with K-character delimiters. It sits between the shared-memory fabric and the transceiver TX data port, paced by the transceiver word strobe.

## Interface
- `AW`, `SHARED_MEM_AW`: AXI address width.
- `DW`, `LLRF_DW` (32): AXI data width; must be 32.
- `WORDS`, 4: 32-bit words per frame; range 1..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle frame request; ignored while `busy`.
- `base_addr`  in  AW  byte address of the first word; sampled on accepted `start`.
- `seg_id`  in  8  segment tag placed in SOF; sampled on accepted `start`.
- `tx_ena`  in  1  transceiver consumes `tx_data_out` on cycles where it is 1.
- `tx_data_out`  out  struct  `.data[15:0]`, `.iskey[1:0]` (bit1 = upper byte).
- `busy`  out  1  high from accepted `start` until EOF has been consumed.
- `err`  out  1  sticky read-error flag; cleared by accepted `start`.
- `shared_data_in_i`  axi4_lite_if master  read channels only (`araddr`, `arvalid`, `arready`, `rdata`, `rresp`, `rvalid`, `rready`); write channels tied inactive (`awvalid`=`wvalid`=0, `bready`=1).

## Operation
- Word codes: IDLE = 0xBCBC, iskey 2'b11 (K28.5 K28.5). SOF = {0xFB, seg_id}, iskey 2'b10. HDR = `base_addr[15:0]` (zero-extended if AW<16), iskey 2'b00. DATA = 16-bit halves, upper half first, iskey 2'b00. CSUM = 16-bit sum of all DATA halves mod 2^16, iskey 2'b00. EOF = {0xFD, 0xBC}, iskey 2'b11.
- FSM: IDLE -> FETCH -> SOF -> HDR -> DATA -> CSUM -> EOF -> IDLE.
- IDLE: output IDLE word; accepted `start` -> FETCH, `err`<=0, word counter <=0.
- FETCH: one outstanding read. Address n = `base_addr` + 4*n. Words are stored in an internal WORDS×32 buffer. After the WORDS-th R beat -> SOF.
- Any R beat with `rresp`≠2'b00: `err`<=1, discard the buffer, -> IDLE. No SOF is sent and `busy` drops.
- SOF/HDR/CSUM/EOF: each state emits one word, then advances on `tx_ena`.
- DATA: 2*WORDS words emitted in buffer order. The checksum accumulates as each word is emitted.
- Every word is held on `tx_data_out` until a cycle with `tx_ena`=1. The next word appears on the following cycle. No word is dropped or repeated.
- `start` while `busy`: ignored, no effect.

## Timing
- Reset (asserted): `tx_data_out`=IDLE word, `busy`=0, `err`=0, `arvalid`=0, `rready`=0, FSM=IDLE, buffer contents don't-care.
- Reset asserted mid-frame: output reverts to IDLE immediately (async). A partial frame is abandoned and not resumed.
- `start` on cycle t: `busy`=1 and `arvalid`=1 on t+1.
- `arvalid` is held with a stable `araddr` until `arready`. `rready`=1 while a read is outstanding. The next AR is issued the cycle after its R handshake.
- SOF appears on `tx_data_out` the cycle after the last R handshake.
- Frame length: 4+2*WORDS words, or 3+2*WORDS without checksum. With WORDS=4 and CSUM enabled: 12 consumed words.
- `busy` falls the cycle after EOF is consumed. A `start` on that same cycle is accepted.
- `arready`, `rvalid` and `tx_ena` may all be high simultaneously in any cycle. Read and TX activity never overlap by construction.

## Configuration
- `STREAM_ENCODER_CSUM_EN` defined: CSUM state present; the checksum word is sent between the last DATA and EOF.
- Not defined: CSUM state and accumulator removed; EOF follows the last DATA word directly.

## Test plan
- Reset, then hold `tx_ena` toggling every cycle with no `start` -> continuous 0xBCBC/iskey 2'b11, `busy`=0, no AR.
- `base_addr`=0x400, `seg_id`=0x01, memory = DEADBEEF, 5555AAAA, 11112222, 33334444 -> reads at 0x400/0x404/0x408/0x40C. Stream: FB01, 0400, DEAD, BEEF, 5555, AAAA, 1111, 2222, 3333, 4444, 4845, FDBC, then idle.
- Same frame with `arready` delayed 3 cycles and `tx_ena` toggling -> identical word sequence, each word held until `tx_ena`.
- Second read returns `rresp`=2'b10 -> `err`=1, no FB word ever emitted, `busy`=0 after the R beat. A new `start` clears `err`.
- `start` pulsed mid-frame, then `rst_n` low during DATA -> the mid-frame start is ignored. Output becomes 0xBCBC and `busy`=0 within the reset cycle.
- Build without `STREAM_ENCODER_CSUM_EN` -> 11-word frame; FDBC follows 4444 directly.
